data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised byte-addressable data memory for the core's memory stage. It replaces the fixed 64×64 word store with a configurable XLEN/DEPTH array that takes RV64I load/store funct3 encodings and performs byte, half, word and double accesses with byte-lane write enables and sign or zero extension. Requests use a valid/ready handshake, and results come back on a registered response strobe. After reset, a hardware clear sequence zeroes the whole array.

## Interface
- XLEN, 64, data width in bits; legal values 32 or 64
- DEPTH, 512, number of XLEN-bit words; power of two, ≥ 2
- i_Clock  in  1  clock, rising edge
- i_Reset_n  in  1  synchronous, active-low reset
- i_Valid  in  1  request valid
- o_Ready  out  1  block can accept a request this cycle
- i_MemWrite  in  1  1 = store, 0 = load
- i_Funct3  in  3  RV size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- i_Address  in  64  byte address
- i_Data  in  XLEN  store data, right-aligned (low bytes used)
- o_Valid  out  1  one-cycle response strobe, for loads and stores
- o_ReadData  out  XLEN  load result, extended; 0 for stores and errors
- o_Error  out  1  valid with o_Valid; request rejected with no memory side effect

## Operation
- Derived widths:
  - BL = log2(XLEN/8) byte-offset bits.
  - IW = log2(DEPTH) index bits.
  - Word index = i_Address[BL+IW-1:BL].
  - Byte offset = i_Address[BL-1:0].
- FSM states:
  - CLEAR: o_Ready = 0. A counter steps 0..DEPTH-1 and writes zero to one word per cycle. After it writes word DEPTH-1, go to RUN.
  - RUN: o_Ready = 1.
- Reset: while i_Reset_n = 0 at an edge, state = CLEAR, counter = 0, o_Valid = 0, o_Error = 0, o_ReadData = 0, o_Ready = 0. Reset mid-CLEAR or mid-RUN restarts the clear from word 0.
- Accept: a request is taken when i_Valid & o_Ready at a rising edge. There is no response backpressure. i_Valid outside RUN is ignored and produces no response.
- Error conditions, checked in priority order; any one sets o_Error = 1 and leaves the array unchanged:
  - Illegal size: funct3 = 111; 011 or 110 when XLEN = 32; or any funct3 with bit 2 set on a store.
  - Misaligned: address not a multiple of the access size.
  - Out of range: any i_Address bit above BL+IW-1 is 1.
- Store:
  - Size bytes = 1/2/4/8.
  - The low size bytes of i_Data are written into lanes [offset, offset+size-1] of the indexed word.
  - Other lanes keep their value.
- Load:
  - Extract size bytes starting at lane offset.
  - Funct3 000/001/010 sign-extend to XLEN; 100/101/110 zero-extend; 011 (XLEN = 64) is the full word.

## Timing
- Latency: exactly 1 cycle. A request accepted at edge N gives o_Valid = 1 during the cycle after edge N, with o_ReadData and o_Error valid in that cycle.
- Back-to-back requests are accepted every cycle in RUN, giving throughput 1 per cycle.
- Outputs are all registered:
  - o_Valid is 0 in any cycle following an edge with no accepted request.
  - o_ReadData and o_Error return to 0 whenever o_Valid = 0.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the post-store data.
  - Load data is read from the array state that exists before the load's own edge.
- Clear duration: o_Ready first becomes 1 after DEPTH rising edges with i_Reset_n = 1.
- Memory contents are never undefined after reset: every word reads 0 until written.

## Test plan
- Reset/clear (DEPTH = 16): hold i_Reset_n = 0 for 3 edges, then release. Required: o_Ready = 0 for 16 edges, then 1. A LD at address 0x78 returns 0. Asserting reset again at clear step 5 restarts the clear with a full 16-edge count.
- Byte-lane store/sign-extend (XLEN = 64):
  - SD 0x0123456789ABCDEF to 0x10, then SB 0x80 to 0x13.
  - LB 0x13 returns 0xFFFFFFFFFFFFFF80.
  - LBU 0x13 returns 0x80.
  - LD 0x10 returns 0x0123456780ABCDEF.
- Half/word extension:
  - SW 0x8000F00D to 0x20.
  - LW 0x20 returns 0xFFFFFFFF8000F00D.
  - LWU 0x20 returns 0x000000008000F00D.
  - LH 0x22 returns 0xFFFFFFFFFFFF8000.
  - LHU 0x20 returns 0xF00D.
- Errors:
  - Each of these gives o_Valid = 1, o_Error = 1, o_ReadData = 0, and the word is unchanged on a subsequent LD: SH to 0x21, LD from 0x0C, SD to 0x80 (DEPTH = 16), funct3 = 111, and SBU (store with funct3 100).
- Pipelining/RAW:
  - Issue SD 0xAA to 0x08 then LD 0x08 on consecutive cycles with i_Valid held high.
  - Required: two consecutive o_Valid pulses; the second returns 0xAA.
  - i_Valid = 0 for one cycle then gives o_Valid = 0 in the matching cycle.
- XLEN = 32 build:
  - LD gives o_Error = 1.
  - SW 0xDEADBEEF to 0x4, then LH 0x6, returns 0xFFFFDEAD.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the memory stage and the data memory.
// The core drives the request side (master); data_mem_lsu answers (slave).
interface data_mem_lsu_if #(
    parameter int XLEN = 64
);
    logic            i_Valid;
    logic            o_Ready;
    logic            i_MemWrite;
    logic [2:0]      i_Funct3;
    logic [63:0]     i_Address;
    logic [XLEN-1:0] i_Data;
    logic            o_Valid;
    logic [XLEN-1:0] o_ReadData;
    logic            o_Error;

    modport master (
        output i_Valid, i_MemWrite, i_Funct3, i_Address, i_Data,
        input  o_Ready, o_Valid, o_ReadData, o_Error
    );

    modport slave (
        input  i_Valid, i_MemWrite, i_Funct3, i_Address, i_Data,
        output o_Ready, o_Valid, o_ReadData, o_Error
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory for the memory stage. Takes RV64I load/store
// funct3 codes, performs B/H/W/D accesses with byte-lane enables and
// sign/zero extension, answers one cycle later on a registered strobe, and
// zeroes the whole array with a hardware clear sequence after reset.
module data_mem_lsu #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 512
) (
    input  logic           i_Clock,
    input  logic           i_Reset_n,
    data_mem_lsu_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     clr_cnt_q;
    logic              clr_we;
    logic              ready;

    logic [XLEN-1:0]   mem [DEPTH];

    logic [IW-1:0]     idx;
    logic [BL-1:0]     off;
    logic [3:0]        size_bytes;
    logic [3:0]        size_mask;
    logic [7:0]        be_size;
    logic [7:0]        be_shifted;
    logic [NB-1:0]     be;
    logic [63:0]       wdata64;
    logic [XLEN-1:0]   wdata;
    logic [63:0]       rd_shifted;
    logic [63:0]       rd_ext;
    logic [XLEN-1:0]   load_data;
    logic              illegal_size;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic              accept;
    logic              store_ok;

    logic              valid_q;
    logic              error_q;
    logic [XLEN-1:0]   rdata_q;

    assign idx = bus.i_Address[BL+IW-1:BL];
    assign off = bus.i_Address[BL-1:0];

    // State register for the clear/run sequencer.
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update together from values sampled before the edge.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode for the sequencer.
    // NOTE: every output of a combinational block is defaulted first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = i_Reset_n;
                if (clr_cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Clear counter: walks word indices while clearing, restarts on reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    // Request decode: access size, lane enables, aligned store data, errors.
    always_comb begin
        case (bus.i_Funct3[1:0])
            2'b00:   begin size_bytes = 4'd1; be_size = 8'h01; end
            2'b01:   begin size_bytes = 4'd2; be_size = 8'h03; end
            2'b10:   begin size_bytes = 4'd4; be_size = 8'h0F; end
            default: begin size_bytes = 4'd8; be_size = 8'hFF; end
        endcase
        size_mask  = size_bytes - 4'd1;
        be_shifted = be_size << off;
        be         = be_shifted[NB-1:0];
        wdata64    = 64'(bus.i_Data) << {off, 3'b000};
        wdata      = wdata64[XLEN-1:0];

        illegal_size = (bus.i_Funct3 == 3'b111)
                     || ((XLEN == 32) && ((bus.i_Funct3 == 3'b011) || (bus.i_Funct3 == 3'b110)))
                     || (bus.i_MemWrite && bus.i_Funct3[2]);
        misaligned   = (bus.i_Address[3:0] & size_mask) != 4'd0;
        out_of_range = (bus.i_Address >> (BL + IW)) != 64'd0;
        req_err      = illegal_size || misaligned || out_of_range;

        accept   = bus.i_Valid && ready && i_Reset_n;
        store_ok = accept && bus.i_MemWrite && !req_err;
    end

    // Load path: shift the addressed lanes down, then extend to XLEN.
    always_comb begin
        rd_shifted = 64'(mem[idx]) >> {off, 3'b000};
        case (bus.i_Funct3)
            3'b000:  rd_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  rd_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  rd_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'b100:  rd_ext = {56'd0, rd_shifted[7:0]};
            3'b101:  rd_ext = {48'd0, rd_shifted[15:0]};
            3'b110:  rd_ext = {32'd0, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
        load_data = rd_ext[XLEN-1:0];
    end

    // Array write port: zero one word per cycle while clearing, else stores.
    // NOTE: the array itself has no reset; the clear sequencer is what
    // guarantees defined contents, so this block stays a plain RAM write.
    always_ff @(posedge i_Clock) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (store_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered response: one strobe per accepted request, zeros otherwise.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            error_q <= req_err;
            rdata_q <= (req_err || bus.i_MemWrite) ? '0 : load_data;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end
    end

    assign bus.o_Ready    = ready;
    assign bus.o_Valid    = valid_q;
    assign bus.o_Error    = error_q;
    assign bus.o_ReadData = rdata_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a 64-bit and a 32-bit instance (both
// DEPTH = 16) are driven with directed and random requests; a byte-array
// model predicts each response, and a monitor compares on every strobe.
module tb_data_mem_lsu;
    logic i_Clock   = 1'b0;
    logic i_Reset_n = 1'b0;

    always #5 i_Clock = ~i_Clock;

    data_mem_lsu_if #(.XLEN(64)) bus64 ();
    data_mem_lsu_if #(.XLEN(32)) bus32 ();

    data_mem_lsu #(.XLEN(64), .DEPTH(16)) u_dut64 (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .bus       (bus64.slave)
    );

    data_mem_lsu #(.XLEN(32), .DEPTH(16)) u_dut32 (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .bus       (bus32.slave)
    );

    typedef struct {
        int         cyc;
        bit         err;
        bit [63:0]  rd;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Byte-level image of each instance: 16 words * 8 or 4 bytes.
    logic [7:0] mb [2][128];

    always @(posedge i_Clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 128; j++)
                mb[i][j] = 8'h00;
    endfunction

    // Reference behaviour: byte array, plain arithmetic on addresses.
    function automatic void model(input int inst, input bit we, input bit [2:0] f3,
                                  input bit [63:0] addr, input bit [63:0] data,
                                  output bit err, output bit [63:0] rd);
        int  xlen;
        int  size;
        int  total;
        bit  illegal;
        bit  mis;
        bit  oor;
        xlen    = (inst == 0) ? 64 : 32;
        size    = 1 << f3[1:0];
        total   = 16 * (xlen / 8);
        illegal = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) || (we && f3[2]);
        mis     = (addr % size) != 0;
        oor     = addr >= 64'(total);
        err     = illegal || mis || oor;
        rd      = 64'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++)
                mb[inst][int'(addr) + i] = data[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++)
                rd[8*i +: 8] = mb[inst][int'(addr) + i];
            if (!f3[2] && size < 8 && rd[size*8-1])
                for (int b = size * 8; b < 64; b++) rd[b] = 1'b1;
            if (xlen == 32) rd[63:32] = 32'd0;
        end
    endfunction

    function automatic int qsize(input int inst);
        return (inst == 0) ? q64.size() : q32.size();
    endfunction

    function automatic exp_t qpop(input int inst);
        if (inst == 0) return q64.pop_front();
        return q32.pop_front();
    endfunction

    function automatic exp_t qpeek(input int inst);
        if (inst == 0) return q64[0];
        return q32[0];
    endfunction

    task automatic mon_port(input int inst, input logic v, input logic e, input logic [63:0] d);
        exp_t x;
        if (v === 1'b1) begin
            if (qsize(inst) == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp%0d: got o_Valid=1, required no response", inst);
            end else begin
                x = qpop(inst);
                check($sformatf("rsp%0d_cycle", inst), 64'(cyc), 64'(x.cyc));
                check($sformatf("rsp%0d_error", inst), {63'd0, e}, {63'd0, x.err});
                check($sformatf("rsp%0d_rdata", inst), d, x.rd);
            end
        end else begin
            check($sformatf("idle%0d_error", inst), {63'd0, e}, 64'd0);
            check($sformatf("idle%0d_rdata", inst), d, 64'd0);
            if (qsize(inst) > 0 && qpeek(inst).cyc <= cyc) begin
                x = qpop(inst);
                tests++;
                fails++;
                $display("FAIL missed_rsp%0d: got o_Valid=%b, required 1 at cycle %0d", inst, v, x.cyc);
            end
        end
    endtask

    // Monitor: samples both instances on the falling edge.
    always @(negedge i_Clock) begin
        if (mon_en) begin
            mon_port(0, bus64.o_Valid, bus64.o_Error, 64'(bus64.o_ReadData));
            mon_port(1, bus32.o_Valid, bus32.o_Error, 64'(bus32.o_ReadData));
        end
    end

    task automatic idle(input int n);
        bus64.i_Valid = 1'b0;
        bus32.i_Valid = 1'b0;
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    // Drive one request for one cycle; valid stays high so calls chain back-to-back.
    task automatic issue(input int inst, input bit we, input bit [2:0] f3,
                         input bit [63:0] addr, input bit [63:0] data,
                         input bit use_k, input bit k_err, input bit [63:0] k_rd);
        exp_t x;
        bit   e;
        bit [63:0] r;
        logic rdy;
        if (inst == 0) begin
            bus32.i_Valid    = 1'b0;
            bus64.i_Valid    = 1'b1;
            bus64.i_MemWrite = we;
            bus64.i_Funct3   = f3;
            bus64.i_Address  = addr;
            bus64.i_Data     = data;
            rdy              = bus64.o_Ready;
        end else begin
            bus64.i_Valid    = 1'b0;
            bus32.i_Valid    = 1'b1;
            bus32.i_MemWrite = we;
            bus32.i_Funct3   = f3;
            bus32.i_Address  = addr;
            bus32.i_Data     = data[31:0];
            rdy              = bus32.o_Ready;
        end
        if (rdy === 1'b1) begin
            model(inst, we, f3, addr, data, e, r);
            x.cyc = cyc + 1;
            x.err = use_k ? k_err : e;
            x.rd  = use_k ? k_rd : r;
            if (inst == 0) q64.push_back(x);
            else           q32.push_back(x);
        end
        @(posedge i_Clock);
        #1;
    endtask

    task automatic req(input int inst, input bit we, input bit [2:0] f3,
                       input bit [63:0] addr, input bit [63:0] data);
        issue(inst, we, f3, addr, data, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic reqk(input int inst, input bit we, input bit [2:0] f3,
                        input bit [63:0] addr, input bit [63:0] data,
                        input bit k_err, input bit [63:0] k_rd);
        issue(inst, we, f3, addr, data, 1'b1, k_err, k_rd);
    endtask

    task automatic count_clear(output int n);
        n = 0;
        do begin
            @(posedge i_Clock);
            #1;
            n++;
        end while (bus64.o_Ready !== 1'b1 && n < 200);
    endtask

    int n_edges;

    initial begin
        bus64.i_Valid = 1'b0; bus64.i_MemWrite = 1'b0; bus64.i_Funct3 = 3'd0;
        bus64.i_Address = 64'd0; bus64.i_Data = 64'd0;
        bus32.i_Valid = 1'b0; bus32.i_MemWrite = 1'b0; bus32.i_Funct3 = 3'd0;
        bus32.i_Address = 64'd0; bus32.i_Data = 32'd0;

        // Reset for three edges, then check the reset state.
        i_Reset_n = 1'b0;
        repeat (3) @(posedge i_Clock);
        #1;
        check("reset_ready",  {63'd0, bus64.o_Ready}, 64'd0);
        check("reset_valid",  {63'd0, bus64.o_Valid}, 64'd0);
        check("reset_error",  {63'd0, bus64.o_Error}, 64'd0);
        check("reset_rdata",  bus64.o_ReadData, 64'd0);
        check("reset_ready32", {63'd0, bus32.o_Ready}, 64'd0);
        mon_en = 1'b1;
        clear_model();
        i_Reset_n = 1'b1;
        count_clear(n_edges);
        check("clear_edges", 64'(n_edges), 64'd16);
        check("clear_ready32", {63'd0, bus32.o_Ready}, 64'd1);

        // Cleared memory reads zero.
        reqk(0, 1'b0, 3'b011, 64'h78, 64'd0, 1'b0, 64'd0);

        // Byte-lane store and sign/zero extension.
        reqk(0, 1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 1'b0, 64'd0);
        reqk(0, 1'b1, 3'b000, 64'h13, 64'h80, 1'b0, 64'd0);
        reqk(0, 1'b0, 3'b000, 64'h13, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF80);
        reqk(0, 1'b0, 3'b100, 64'h13, 64'd0, 1'b0, 64'h80);
        reqk(0, 1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'h0123456780ABCDEF);

        // Half/word extension.
        reqk(0, 1'b1, 3'b010, 64'h20, 64'h8000F00D, 1'b0, 64'd0);
        reqk(0, 1'b0, 3'b010, 64'h20, 64'd0, 1'b0, 64'hFFFFFFFF8000F00D);
        reqk(0, 1'b0, 3'b110, 64'h20, 64'd0, 1'b0, 64'h000000008000F00D);
        reqk(0, 1'b0, 3'b001, 64'h22, 64'd0, 1'b0, 64'hFFFFFFFFFFFF8000);
        reqk(0, 1'b0, 3'b101, 64'h20, 64'd0, 1'b0, 64'h000000000000F00D);

        // Error cases, each followed by a read-back proving no side effect.
        reqk(0, 1'b1, 3'b001, 64'h21, 64'hBEEF, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h20, 64'd0, 1'b0, 64'h000000008000F00D);
        reqk(0, 1'b0, 3'b011, 64'h0C, 64'd0, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h08, 64'd0, 1'b0, 64'd0);
        reqk(0, 1'b1, 3'b011, 64'h80, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h00, 64'd0, 1'b0, 64'd0);
        reqk(0, 1'b1, 3'b111, 64'h30, 64'h1234, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b111, 64'h30, 64'd0, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h30, 64'd0, 1'b0, 64'd0);
        reqk(0, 1'b1, 3'b100, 64'h18, 64'h55, 1'b1, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h18, 64'd0, 1'b0, 64'd0);

        // Back-to-back store then load of the same word, then a gap cycle.
        reqk(0, 1'b1, 3'b011, 64'h08, 64'hAA, 1'b0, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h08, 64'd0, 1'b0, 64'hAA);
        idle(1);
        reqk(0, 1'b0, 3'b000, 64'h08, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFFAA);
        idle(2);

        // 32-bit build.
        reqk(1, 1'b0, 3'b011, 64'h0, 64'd0, 1'b1, 64'd0);
        reqk(1, 1'b1, 3'b010, 64'h4, 64'hDEADBEEF, 1'b0, 64'd0);
        reqk(1, 1'b0, 3'b001, 64'h6, 64'd0, 1'b0, 64'hFFFFDEAD);
        reqk(1, 1'b0, 3'b010, 64'h4, 64'd0, 1'b0, 64'hDEADBEEF);
        reqk(1, 1'b0, 3'b110, 64'h4, 64'd0, 1'b1, 64'd0);
        reqk(1, 1'b0, 3'b000, 64'h41, 64'd0, 1'b1, 64'd0);
        idle(2);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            int        inst;
            bit [63:0] addr;
            bit [63:0] data;
            inst = $urandom_range(0, 1);
            addr = 64'($urandom_range(0, (inst == 0) ? 135 : 67));
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~64'((1 << $urandom_range(0, 3)) - 1);
            if ($urandom_range(0, 31) == 0)
                addr = {$urandom, $urandom};
            data = {$urandom, $urandom};
            req(inst, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, data);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(2);

        // Reset partway through a clear restarts the full count; requests
        // presented while clearing are ignored.
        i_Reset_n = 1'b0;
        @(posedge i_Clock);
        #1;
        i_Reset_n = 1'b1;
        repeat (5) @(posedge i_Clock);
        #1;
        i_Reset_n = 1'b0;
        @(posedge i_Clock);
        #1;
        clear_model();
        i_Reset_n        = 1'b1;
        bus64.i_Valid    = 1'b1;
        bus64.i_MemWrite = 1'b1;
        bus64.i_Funct3   = 3'b011;
        bus64.i_Address  = 64'h78;
        bus64.i_Data     = 64'hFFFFFFFFFFFFFFFF;
        count_clear(n_edges);
        check("restart_clear_edges", 64'(n_edges), 64'd16);
        reqk(0, 1'b0, 3'b011, 64'h78, 64'd0, 1'b0, 64'd0);
        reqk(0, 1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'd0);
        reqk(1, 1'b0, 3'b010, 64'h4, 64'd0, 1'b0, 64'd0);
        idle(3);

        check("drain_q64", 64'(q64.size()), 64'd0);
        check("drain_q32", 64'(q32.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
